// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out bus between a word producer and piso_serializer.
//
// Handshake: a word on data_in is transferred at a rising clk edge only when
// load and ready are both 1 in the cycle before that edge; at any other edge
// load is ignored. sout carries a frame bit exactly when sout_valid is 1,
// and last marks the final bit of each frame. ready is 1 while the
// serializer is idle and during the final bit of a frame.
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             last;

  // Word producer side.
  modport master (
    output data_in,
    output load,
    input  ready,
    input  sout,
    input  sout_valid,
    input  last
  );

  // Serializer side.
  modport slave (
    input  data_in,
    input  load,
    output ready,
    output sout,
    output sout_valid,
    output last
  );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial converter with registered serial outputs.
// A word accepted at edge N shows its MSB on sout in cycle N+1 and bit 0 in
// cycle N+WIDTH. A new word may be accepted during the final frame cycle,
// so consecutive frames run with no idle gap.
//
// Optional feature: define PISO_SERIALIZER_PARITY_EN to append one
// even-parity bit (XOR of the data bits) after bit 0, giving WIDTH+1
// cycle frames. Without it the PARITY state and parity logic are absent.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  piso_serializer_if.slave     bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PISO_SERIALIZER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ready_c;
  logic             accept;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready while idle or while the final frame bit is on the wire.
  always_comb begin
    ready_c = (state_q == IDLE) || last_q;
    accept  = bus.load && ready_c;
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; cnt_q counts data bits still to follow the one on sout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next values of the shift register, counter and registered serial outputs.
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      // MSB goes straight to the output register; the rest waits MSB-aligned.
      sout_d  = bus.data_in[WIDTH-1];
      sreg_d  = {bus.data_in[WIDTH-2:0], 1'b0};
      cnt_d   = CW'(WIDTH - 1);
      valid_d = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d   = ^bus.data_in;
`endif
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        sout_d  = sreg_q[WIDTH-1];
        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        valid_d = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
        last_d  = 1'b0;
`else
        last_d  = (cnt_q == CW'(1));
`endif
      end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
        sout_d  = par_q;
        valid_d = 1'b1;
        last_d  = 1'b1;
`endif
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Drive the bus and the state debug port.
  always_comb begin
    bus.ready      = ready_c;
    bus.sout       = sout_q;
    bus.sout_valid = valid_q;
    bus.last       = last_q;
    dbg_state      = state_q;
  end

endmodule
